// File: rtl/univ_shift_register.sv
// Parametrised universal shift register: hold, shift left/right, parallel load,
// with a shift counter that pulses word_done on each completed WIDTH-bit word.
// Optional rotate input when UNIV_SHIFT_ROTATE_EN is defined.
module univ_shift_register #(
    parameter int unsigned       WIDTH       = 8,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic                         serial_in_l,
    input  logic                         serial_in_r,
    input  logic [WIDTH-1:0]             parallel_in,
`ifdef UNIV_SHIFT_ROTATE_EN
    input  logic                         rotate,
`endif
    output logic [WIDTH-1:0]             q,
    output logic                         serial_out_msb,
    output logic                         serial_out_lsb,
    output logic [$clog2(WIDTH+1)-1:0]   shift_count,
    output logic                         word_done
);

    localparam int unsigned    CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHL   = 2'b01,
        MODE_SHR   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    mode_e           mode_sel;
    logic            rot;
    logic            fill_l;
    logic            fill_r;
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]   count_next;
    logic            done_next;

    assign mode_sel = mode_e'(mode);

`ifdef UNIV_SHIFT_ROTATE_EN
    assign rot = rotate;
`else
    assign rot = 1'b0;
`endif

    // While rotating, the bit leaving one end re-enters at the other.
    assign fill_l = rot ? q[WIDTH-1] : serial_in_l;
    assign fill_r = rot ? q[0]       : serial_in_r;

    always_comb begin
        q_next     = q;
        count_next = shift_count;
        done_next  = 1'b0;
        if (en) begin
            unique case (mode_sel)
                MODE_HOLD: begin
                    q_next = q;
                end
                MODE_SHL: begin
                    q_next = {q[WIDTH-2:0], fill_l};
                end
                MODE_SHR: begin
                    q_next = {fill_r, q[WIDTH-1:1]};
                end
                MODE_LOAD: begin
                    q_next     = parallel_in;
                    count_next = '0;
                end
            endcase
            if (mode_sel == MODE_SHL || mode_sel == MODE_SHR) begin
                if (shift_count == LAST) begin
                    count_next = '0;
                    done_next  = 1'b1;
                end else begin
                    count_next = shift_count + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q           <= RESET_VALUE;
            shift_count <= '0;
            word_done   <= 1'b0;
        end else begin
            q           <= q_next;
            shift_count <= count_next;
            word_done   <= done_next;
        end
    end

    assign serial_out_msb = q[WIDTH-1];
    assign serial_out_lsb = q[0];

endmodule

// File: tb/tb_univ_shift_register.sv
// Directed, table-driven bench for univ_shift_register at WIDTH=4.
module tb_univ_shift_register;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = $clog2(W + 1);

    logic          clk;
    logic          rst;
    logic          en;
    logic [1:0]    mode;
    logic          serial_in_l;
    logic          serial_in_r;
    logic [W-1:0]  parallel_in;
`ifdef UNIV_SHIFT_ROTATE_EN
    logic          rotate;
`endif
    logic [W-1:0]  q;
    logic          serial_out_msb;
    logic          serial_out_lsb;
    logic [CW-1:0] shift_count;
    logic          word_done;

    univ_shift_register #(
        .WIDTH       (W),
        .RESET_VALUE (4'b0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .mode           (mode),
        .serial_in_l    (serial_in_l),
        .serial_in_r    (serial_in_r),
        .parallel_in    (parallel_in),
`ifdef UNIV_SHIFT_ROTATE_EN
        .rotate         (rotate),
`endif
        .q              (q),
        .serial_out_msb (serial_out_msb),
        .serial_out_lsb (serial_out_lsb),
        .shift_count    (shift_count),
        .word_done      (word_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          en;
        logic [1:0]    mode;
        logic          sil;
        logic          sir;
        logic [W-1:0]  pin;
        logic          rot;
        logic [W-1:0]  eq;
        logic [CW-1:0] ec;
        logic          ed;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic r, logic e, logic [1:0] m, logic sl, logic sr,
                                logic [W-1:0] p, logic ro, logic [W-1:0] xq,
                                logic [CW-1:0] xc, logic xd);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.sil = sl; v.sir = sr; v.pin = p;
        v.rot = ro; v.eq = xq; v.ec = xc; v.ed = xd;
        return v;
    endfunction

    task automatic check(string name, logic [W-1:0] xq, logic [CW-1:0] xc, logic xd);
        n_vec++;
        if (q !== xq) begin
            n_fail++;
            $display("FAIL %s q: got %b expected %b", name, q, xq);
        end
        if (shift_count !== xc) begin
            n_fail++;
            $display("FAIL %s shift_count: got %0d expected %0d", name, shift_count, xc);
        end
        if (word_done !== xd) begin
            n_fail++;
            $display("FAIL %s word_done: got %b expected %b", name, word_done, xd);
        end
        if (serial_out_msb !== xq[W-1]) begin
            n_fail++;
            $display("FAIL %s serial_out_msb: got %b expected %b", name, serial_out_msb, xq[W-1]);
        end
        if (serial_out_lsb !== xq[0]) begin
            n_fail++;
            $display("FAIL %s serial_out_lsb: got %b expected %b", name, serial_out_lsb, xq[0]);
        end
    endtask

    task automatic apply(vec_t v, string name);
        @(negedge clk);
        rst         = v.rst;
        en          = v.en;
        mode        = v.mode;
        serial_in_l = v.sil;
        serial_in_r = v.sir;
        parallel_in = v.pin;
`ifdef UNIV_SHIFT_ROTATE_EN
        rotate      = v.rot;
`endif
        @(posedge clk);
        #1;
        check(name, v.eq, v.ec, v.ed);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'b00;
        serial_in_l = 1'b0; serial_in_r = 1'b0; parallel_in = '0;
`ifdef UNIV_SHIFT_ROTATE_EN
        rotate = 1'b0;
`endif
        #2;
        check("reset_init", 4'b0000, 0, 1'b0);

        // rst en mode sil sir pin rot | q cnt done
        // serial-in left 1,0,1,1
        vecs.push_back(mk(0,1,2'b01,1,0,4'b0000,0, 4'b0001,1,0));
        vecs.push_back(mk(0,1,2'b01,0,0,4'b0000,0, 4'b0010,2,0));
        vecs.push_back(mk(0,1,2'b01,1,0,4'b0000,0, 4'b0101,3,0));
        vecs.push_back(mk(0,1,2'b01,1,0,4'b0000,0, 4'b1011,0,1));
        vecs.push_back(mk(0,1,2'b00,0,0,4'b0000,0, 4'b1011,0,0));
        // load 1001 then shift right with zeros
        vecs.push_back(mk(0,1,2'b11,0,0,4'b1001,0, 4'b1001,0,0));
        vecs.push_back(mk(0,1,2'b10,0,0,4'b0000,0, 4'b0100,1,0));
        vecs.push_back(mk(0,1,2'b10,0,0,4'b0000,0, 4'b0010,2,0));
        vecs.push_back(mk(0,1,2'b10,0,0,4'b0000,0, 4'b0001,3,0));
        vecs.push_back(mk(0,1,2'b10,0,0,4'b0000,0, 4'b0000,0,1));
        vecs.push_back(mk(0,1,2'b10,1,1,4'b0000,0, 4'b1000,1,0));
        // enable/hold after 2 shifts, then mixed-direction completion
        vecs.push_back(mk(0,1,2'b11,0,0,4'b0000,0, 4'b0000,0,0));
        vecs.push_back(mk(0,1,2'b01,1,0,4'b0000,0, 4'b0001,1,0));
        vecs.push_back(mk(0,1,2'b01,1,0,4'b0000,0, 4'b0011,2,0));
        vecs.push_back(mk(0,0,2'b01,1,1,4'b0000,0, 4'b0011,2,0));
        vecs.push_back(mk(0,0,2'b10,1,1,4'b0000,0, 4'b0011,2,0));
        vecs.push_back(mk(0,0,2'b11,1,1,4'b1111,0, 4'b0011,2,0));
        vecs.push_back(mk(0,1,2'b00,1,1,4'b1111,0, 4'b0011,2,0));
        vecs.push_back(mk(0,1,2'b00,0,0,4'b1111,0, 4'b0011,2,0));
        vecs.push_back(mk(0,1,2'b10,0,1,4'b0000,0, 4'b1001,3,0));
        vecs.push_back(mk(0,1,2'b01,0,0,4'b0000,0, 4'b0010,0,1));
        vecs.push_back(mk(0,0,2'b01,1,0,4'b0000,0, 4'b0010,0,0));
        // load mid-word discards partial count
        vecs.push_back(mk(0,1,2'b11,0,0,4'b0000,0, 4'b0000,0,0));
        vecs.push_back(mk(0,1,2'b01,1,0,4'b0000,0, 4'b0001,1,0));
        vecs.push_back(mk(0,1,2'b01,1,0,4'b0000,0, 4'b0011,2,0));
        vecs.push_back(mk(0,1,2'b01,1,0,4'b0000,0, 4'b0111,3,0));
        vecs.push_back(mk(0,1,2'b11,0,0,4'b0110,0, 4'b0110,0,0));
        vecs.push_back(mk(0,1,2'b10,0,1,4'b0000,0, 4'b1011,1,0));
        vecs.push_back(mk(0,1,2'b10,0,0,4'b0000,0, 4'b0101,2,0));
        vecs.push_back(mk(0,1,2'b10,0,0,4'b0000,0, 4'b0010,3,0));
        vecs.push_back(mk(0,1,2'b10,0,1,4'b0000,0, 4'b1001,0,1));
        // back-to-back words
        vecs.push_back(mk(0,1,2'b01,0,0,4'b0000,0, 4'b0010,1,0));
        vecs.push_back(mk(0,1,2'b01,0,0,4'b0000,0, 4'b0100,2,0));
        vecs.push_back(mk(0,1,2'b01,0,0,4'b0000,0, 4'b1000,3,0));
        vecs.push_back(mk(0,1,2'b01,0,0,4'b0000,0, 4'b0000,0,1));
        vecs.push_back(mk(0,1,2'b01,1,0,4'b0000,0, 4'b0001,1,0));
        // reset mid-word, including over a load
        vecs.push_back(mk(0,1,2'b01,1,0,4'b0000,0, 4'b0011,2,0));
        vecs.push_back(mk(1,1,2'b11,1,1,4'b1111,0, 4'b0000,0,0));
        vecs.push_back(mk(0,1,2'b01,1,0,4'b0000,0, 4'b0001,1,0));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // asynchronous reset between edges
        apply(mk(0,1,2'b11,0,0,4'b1111,0, 4'b1111,0,0), "async_pre");
        @(negedge clk);
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_reset", 4'b0000, 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

`ifdef UNIV_SHIFT_ROTATE_EN
        apply(mk(0,1,2'b11,0,0,4'b1000,0, 4'b1000,0,0), "rot_load");
        apply(mk(0,1,2'b01,0,0,4'b0000,1, 4'b0001,1,0), "rot_l1");
        apply(mk(0,1,2'b01,0,0,4'b0000,1, 4'b0010,2,0), "rot_l2");
        apply(mk(0,1,2'b01,0,0,4'b0000,1, 4'b0100,3,0), "rot_l3");
        apply(mk(0,1,2'b01,0,0,4'b0000,1, 4'b1000,0,1), "rot_l4");
        apply(mk(0,1,2'b10,1,1,4'b0000,1, 4'b0100,1,0), "rot_r1");
        apply(mk(0,1,2'b11,0,0,4'b0011,1, 4'b0011,0,0), "rot_load_ign");
        apply(mk(0,1,2'b10,0,0,4'b0000,1, 4'b1001,1,0), "rot_r2");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_shift_register.md
Name: univ_shift_register

Overview:
- Parametrised universal shift register; successor to the fixed 4-bit serial-in shift register.
- Supports hold, shift-left, shift-right and parallel load, selected per cycle.
- A shift counter flags each completed WIDTH-bit word for serial-to-parallel and parallel-to-serial use.
- Sits between bit-serial links and word-wide datapaths in the lab designs.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- en  input  1  cycle enable. When low, all state holds.
- mode  input  2  00 hold, 01 shift left, 10 shift right, 11 parallel load.
- serial_in_l  input  1  bit entering at the LSB on shift left.
- serial_in_r  input  1  bit entering at the MSB on shift right.
- parallel_in  input  WIDTH  data for parallel load.
- q  output  WIDTH  register contents.
- serial_out_msb  output  1  equals q[WIDTH-1] (combinational from q).
- serial_out_lsb  output  1  equals q[0] (combinational from q).
- shift_count  output  $clog2(WIDTH+1)  shifts since last load, reset or wrap.
- word_done  output  1  one-cycle pulse when a WIDTH-bit word completes.

Behaviour:
- Reset (async, rst=1): q=RESET_VALUE, shift_count=0, word_done=0, regardless of clk or en. Release is sampled at the next rising edge.
- All updates occur on the rising clk edge only when en=1.
  - en=0: q and shift_count hold; word_done is cleared to 0.
- mode 00 (hold): q and shift_count unchanged; word_done <= 0.
- mode 01 (shift left): q <= {q[WIDTH-2:0], serial_in_l}.
- mode 10 (shift right): q <= {serial_in_r, q[WIDTH-1:1]}.
- mode 11 (load): q <= parallel_in; shift_count <= 0; word_done <= 0.
- Counter, on each shift (mode 01 or 10, en=1):
  - if shift_count == WIDTH-1: shift_count <= 0 and word_done <= 1;
  - else shift_count <= shift_count+1 and word_done <= 0.
- word_done timing:
  - Registered; high in the cycle immediately after the edge that performed the WIDTH-th shift, i.e. concurrent with q holding the completed word.
  - It is always a single-cycle pulse.
  - Back-to-back words give a pulse every WIDTH shifting cycles.
- Mixed directions: left and right shifts both advance the same counter; direction changes do not reset it.
- Load mid-word: the partial count is discarded and no word_done is produced.
- Reset mid-word: same as load, with q=RESET_VALUE.
- Latency: one clock from input to q. serial_out_* follow q with no additional delay.
- No X propagation: every mode value is decoded, so no illegal states exist.

Optional Feature:
- Macro: UNIV_SHIFT_ROTATE_EN.
- Defined: an extra input port rotate (1 bit).
  - rotate=1 with mode 01: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - rotate=1 with mode 10: q <= {q[0], q[WIDTH-1:1]}.
  - serial_in_l and serial_in_r are ignored while rotating.
  - Counter and word_done behave exactly as for a normal shift.
  - rotate has no effect in modes 00 and 11.
- Undefined: the rotate port does not exist; shifts always take the serial inputs.

Test Plan:
- Reset: WIDTH=4, drive rst=1 mid-cycle with clk idle -> q=0000, shift_count=0, word_done=0 immediately, without waiting for a clock edge.
- Serial-in left: WIDTH=4, en=1, mode=01, serial_in_l sequence 1,0,1,1 on four edges -> q=0001,0010,0101,1011. word_done=1 only in the cycle after the 4th edge; shift_count=0 after it.
- Load then shift right: load parallel_in=1001 -> q=1001, count=0. Then mode=10 with serial_in_r=0 for four edges -> q=0100,0010,0001,0000. serial_out_lsb sequence is 1,0,0,1 (pre-edge values); word_done pulses once.
- Enable/hold: after 2 shifts, set en=0 for 3 cycles, then mode=00 for 2 cycles -> q and shift_count (=2) unchanged, word_done=0. Two more shifts -> word_done pulse.
- Load mid-word: 3 shifts, then load 0110 -> count=0 and no pulse. 4 further shifts produce exactly one pulse.
- Rotate (UNIV_SHIFT_ROTATE_EN): q=1000, rotate=1, mode=01 for 4 edges with serial_in_l=0 -> q=0001,0010,0100,1000, with word_done pulsing after the 4th edge.
